// File: rtl/micro_sequencer.sv
// Micro-program sequencer: holds the micro-address and resolves the next one each
// cycle (increment, dispatch, jumps, call/return through a small return stack, halt).
module micro_sequencer #(
  parameter int            AW          = 6,
  parameter int            STACK_DEPTH = 4,
  parameter logic [AW-1:0] RESET_ADDR  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    sel,
  input  logic [AW-1:0] jump_addr,
  input  logic [AW-1:0] dr_opcode,
  input  logic          z_flag,
  input  logic          mem_wait,
  output logic [AW-1:0] upc,
  output logic [AW-1:0] counter_out,
  output logic          ldir,
  output logic          running,
  output logic          halted,
  output logic          stack_err
);

  // sp needs one extra bit so that "full" (sp == STACK_DEPTH) is representable
  localparam int SPW = $clog2(STACK_DEPTH) + 1;

  localparam logic [2:0] SEL_INC  = 3'b000;
  localparam logic [2:0] SEL_DISP = 3'b001;
  localparam logic [2:0] SEL_JMP  = 3'b010;
  localparam logic [2:0] SEL_JZ   = 3'b011;
  localparam logic [2:0] SEL_JNZ  = 3'b100;
  localparam logic [2:0] SEL_CALL = 3'b101;
  localparam logic [2:0] SEL_RET  = 3'b110;
  localparam logic [2:0] SEL_HALT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t          state;
  logic [SPW-1:0]  sp;
  logic [SPW-1:0]  sp_dec;
  logic [AW-1:0]   upc_inc;
  logic [AW-1:0]   stack [STACK_DEPTH];
  logic [SPW-2:0]  wr_idx;
  logic [SPW-2:0]  rd_idx;
  logic            advance;
  logic            stack_full;
  logic            stack_empty;

  always_comb begin
    upc_inc     = upc + 1'b1;
    sp_dec      = sp - 1'b1;
    wr_idx      = sp[SPW-2:0];
    rd_idx      = sp_dec[SPW-2:0];
    stack_full  = (sp == SPW'(STACK_DEPTH));
    stack_empty = (sp == '0);
    advance     = (state == S_RUN) && !mem_wait;
    counter_out = upc_inc;
    ldir        = advance && (sel == SEL_DISP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      upc       <= RESET_ADDR;
      sp        <= '0;
      stack_err <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (advance) begin
            case (sel)
              SEL_INC:  upc <= upc_inc;
              SEL_DISP: upc <= dr_opcode;
              SEL_JMP:  upc <= jump_addr;
              SEL_JZ:   upc <= z_flag ? jump_addr : upc_inc;
              SEL_JNZ:  upc <= z_flag ? upc_inc : jump_addr;
              SEL_CALL: begin
                if (stack_full) begin
                  stack_err <= 1'b1;
                  state     <= S_HALT;
                  running   <= 1'b0;
                  halted    <= 1'b1;
                end else begin
                  stack[wr_idx] <= upc_inc;
                  sp            <= sp + 1'b1;
                  upc           <= jump_addr;
                end
              end
              SEL_RET: begin
                if (stack_empty) begin
                  stack_err <= 1'b1;
                  state     <= S_HALT;
                  running   <= 1'b0;
                  halted    <= 1'b1;
                end else begin
                  sp  <= sp_dec;
                  upc <= stack[rd_idx];
                end
              end
              SEL_HALT: begin
                state   <= S_HALT;
                running <= 1'b0;
                halted  <= 1'b1;
              end
              default: upc <= upc;
            endcase
          end
        end
        default: begin
          // HALT is terminal; only rst leaves it
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed vector table, hand sequences for stack
// overflow / async reset, and randomized traffic against a queue-based model.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [5:0] jump_addr = 6'd0;
  logic [5:0] dr_opcode = 6'd0;
  logic       z_flag = 1'b0;
  logic       mem_wait = 1'b0;
  logic [5:0] upc, counter_out;
  logic       ldir, running, halted, stack_err;

  micro_sequencer #(.AW(6), .STACK_DEPTH(4), .RESET_ADDR(6'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .jump_addr(jump_addr),
    .dr_opcode(dr_opcode), .z_flag(z_flag), .mem_wait(mem_wait), .upc(upc),
    .counter_out(counter_out), .ldir(ldir), .running(running), .halted(halted),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // reference model: 0 idle, 1 run, 2 halt; return addresses kept in a queue
  int m_state;
  int m_upc;
  int m_err;
  int m_stk[$];
  logic ldir_s;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic s, input logic [2:0] sl, input int ja, input int op,
                            input logic z, input logic mw);
    int inc;
    inc = (m_upc + 1) % 64;
    if (m_state == 0) begin
      if (s) m_state = 1;
    end else if (m_state == 1 && !mw) begin
      case (sl)
        3'd0: m_upc = inc;
        3'd1: m_upc = op;
        3'd2: m_upc = ja;
        3'd3: m_upc = z ? ja : inc;
        3'd4: m_upc = z ? inc : ja;
        3'd5: if (m_stk.size() == 4) begin m_err = 1; m_state = 2; end
              else begin m_stk.push_back(inc); m_upc = ja; end
        3'd6: if (m_stk.size() == 0) begin m_err = 1; m_state = 2; end
              else m_upc = m_stk.pop_back();
        default: m_state = 2;
      endcase
    end
  endtask

  // entered at posedge+1; leaves at the next posedge+1
  task automatic cyc(input logic s, input logic [2:0] sl, input logic [5:0] ja,
                     input logic [5:0] op, input logic z, input logic mw);
    start = s; sel = sl; jump_addr = ja; dr_opcode = op; z_flag = z; mem_wait = mw;
    #1;
    ldir_s = ldir;
    chk("ldir", ldir, (m_state == 1 && !mw && sl == 3'd1) ? 1 : 0);
    chk("counter_out_pre", counter_out, (m_upc + 1) % 64);
    @(posedge clk);
    model_step(s, sl, ja, op, z, mw);
    #1;
    chk("upc", upc, m_upc);
    chk("running", running, m_state == 1 ? 1 : 0);
    chk("halted", halted, m_state == 2 ? 1 : 0);
    chk("stack_err", stack_err, m_err);
    chk("counter_out", counter_out, (m_upc + 1) % 64);
  endtask

  // async reset pulse between edges; outputs must clear with no clock edge
  task automatic do_reset();
    @(negedge clk);
    start = 0; sel = 0; mem_wait = 0; z_flag = 0;
    rst = 1'b1;
    #1;
    m_state = 0; m_upc = 0; m_err = 0; m_stk.delete();
    chk("rst_upc", upc, 0);
    chk("rst_counter_out", counter_out, 1);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stack_err", stack_err, 0);
    chk("rst_ldir", ldir, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       st;
    logic [2:0] sl;
    logic [5:0] ja;
    logic [5:0] op;
    logic       z;
    logic       mw;
    logic       e_ldir;
    logic [5:0] e_upc;
    logic       e_run;
    logic       e_halt;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic [2:0] sl, input logic [5:0] ja,
                              input logic [5:0] op, input logic z, input logic mw,
                              input logic el, input logic [5:0] eu, input logic er,
                              input logic eh, input logic ee);
    vec_t v;
    v.st = st; v.sl = sl; v.ja = ja; v.op = op; v.z = z; v.mw = mw;
    v.e_ldir = el; v.e_upc = eu; v.e_run = er; v.e_halt = eh; v.e_err = ee;
    return v;
  endfunction

  initial begin
    //          st sel   ja  op  z  mw  ldir upc run hlt err
    tbl.push_back(mk(1, 3'd0, 0,  0, 0, 0, 0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0, 0,  1, 1, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0, 0,  2, 1, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0, 0,  3, 1, 0, 0));
    tbl.push_back(mk(0, 3'd1, 0, 55, 0, 0, 1, 55, 1, 0, 0));
    tbl.push_back(mk(0, 3'd2, 63, 0, 0, 0, 0, 63, 1, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0, 0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 3'd3, 20, 0, 1, 0, 0, 20, 1, 0, 0));
    tbl.push_back(mk(0, 3'd4, 20, 0, 1, 0, 0, 21, 1, 0, 0));
    tbl.push_back(mk(0, 3'd2, 10, 0, 0, 0, 0, 10, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 3'd2, 40, 0, 0, 1, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 3'd1, 40, 33, 0, 1, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 3'd2, 40, 0, 0, 0, 0, 40, 1, 0, 0));
    tbl.push_back(mk(0, 3'd2, 5,  0, 0, 0, 0,  5, 1, 0, 0));
    tbl.push_back(mk(0, 3'd5, 30, 0, 0, 0, 0, 30, 1, 0, 0));
    tbl.push_back(mk(0, 3'd5, 50, 0, 0, 0, 0, 50, 1, 0, 0));
    tbl.push_back(mk(0, 3'd6, 0,  0, 0, 0, 0, 31, 1, 0, 0));
    tbl.push_back(mk(0, 3'd6, 0,  0, 0, 0, 0,  6, 1, 0, 0));
    tbl.push_back(mk(0, 3'd6, 0,  0, 0, 0, 0,  6, 0, 1, 1));
    tbl.push_back(mk(1, 3'd0, 0,  0, 0, 0, 0,  6, 0, 1, 1));
    tbl.push_back(mk(1, 3'd2, 9,  0, 0, 0, 0,  6, 0, 1, 1));

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].sl, tbl[i].ja, tbl[i].op, tbl[i].z, tbl[i].mw);
      chk($sformatf("tbl%0d_ldir", i), ldir_s, tbl[i].e_ldir);
      chk($sformatf("tbl%0d_upc", i), upc, tbl[i].e_upc);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].e_run);
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].e_halt);
      chk($sformatf("tbl%0d_err", i), stack_err, tbl[i].e_err);
    end

    // overflow: the fifth nested CALL faults and halts with upc held
    do_reset();
    cyc(1, 3'd0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 3'd5, 6'(i), 0, 0, 0);
    chk("ovf_upc", upc, 4);
    chk("ovf_err", stack_err, 1);
    chk("ovf_halted", halted, 1);

    // reset must also empty the stack: an immediate RET underflows
    do_reset();
    cyc(1, 3'd0, 0, 0, 0, 0);
    cyc(0, 3'd6, 0, 0, 0, 0);
    chk("clr_upc", upc, 0);
    chk("clr_err", stack_err, 1);
    chk("clr_halted", halted, 1);

    // randomized traffic, HALT thinned out so runs last a while
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((m_state == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        logic [2:0] rs;
        rs = 3'($urandom_range(0, 7));
        if (rs == 3'd7 && $urandom_range(0, 15) != 0) rs = 3'd0;
        cyc($urandom_range(0, 3) == 0, rs, 6'($urandom), 6'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
